// File: rtl/tftp_rx_ctrl_pkg.sv
// Shared TFTP receive definitions: opcodes, packet size limits and the
// receive-controller state encoding.
package tftp_rx_ctrl_pkg;

  localparam logic [15:0] OPC_RRQ   = 16'h0001;
  localparam logic [15:0] OPC_WRQ   = 16'h0002;
  localparam logic [15:0] OPC_DATA  = 16'h0003;
  localparam logic [15:0] OPC_ACK   = 16'h0004;
  localparam logic [15:0] OPC_ERROR = 16'h0005;

  localparam int MAX_DATA_DEF = 512;
  localparam int CNT_W_DEF    = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OP1,
    ST_BLK0,
    ST_BLK1,
    ST_DATA,
    ST_CHECK,
    ST_ACK_WAIT,
    ST_DROP
  } rx_state_e;

endpackage

// File: rtl/tftp_rx_ctrl_seq_check.sv
// Expected-block tracker: holds the next block number the transfer needs and
// classifies an incoming block number as in-sequence or a duplicate.
module tftp_rx_ctrl_seq_check (
  input  logic        clk,
  input  logic        reset,
  input  logic        init_i,
  input  logic        adv_i,
  input  logic [15:0] blk_no_i,
  output logic        match_o,
  output logic        dup_o
);

  logic [15:0] exp_q, exp_d;

  // 16-bit increment wraps 0xFFFF to 0x0000 naturally
  always_comb begin
    exp_d = exp_q;
    if (init_i)
      exp_d = 16'h0001;
    else if (adv_i)
      exp_d = exp_q + 16'h0001;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      exp_q <= 16'h0001;
    else
      exp_q <= exp_d;
  end

  assign match_o = (blk_no_i == exp_q);
  assign dup_o   = (blk_no_i == (exp_q - 16'h0001));

endmodule

// File: rtl/tftp_rx_ctrl.sv
// TFTP DATA packet receive sequencer: parses opcode and block number, streams
// data bytes to the file buffer and commits, re-acks or discards the packet.
module tftp_rx_ctrl
  import tftp_rx_ctrl_pkg::*;
#(
  parameter int          MAX_DATA = MAX_DATA_DEF,
  parameter int          CNT_W    = CNT_W_DEF,
  parameter logic [15:0] OP_DATA  = OPC_DATA
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             xfer_start,
  input  logic             rx_valid,
  input  logic             rx_sof,
  input  logic             rx_eof,
  input  logic [7:0]       eth_data,
  input  logic [15:0]      blk_no,
  input  logic             ack_done,
  output logic             blk_en,
  output logic             data_wr,
  output logic [7:0]       data_out,
  output logic [CNT_W-1:0] data_cnt,
  output logic             data_commit,
  output logic             data_discard,
  output logic             ack_req,
  output logic [15:0]      ack_blk,
  output logic             pkt_dup,
  output logic             pkt_err,
  output logic             xfer_done
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DATA);

  rx_state_e        state_q;
  logic [7:0]       byte0_q;
  logic             data_wr_q, commit_q, discard_q, dup_q, err_q;
  logic             ack_req_q, done_q;
  logic [7:0]       data_out_q;
  logic [CNT_W-1:0] data_cnt_q;
  logic [15:0]      ack_blk_q;
  logic             seq_match, seq_dup;

  tftp_rx_ctrl_seq_check u_seq (
    .clk      (clk),
    .reset    (reset),
    .init_i   (xfer_start),
    .adv_i    ((state_q == ST_CHECK) && seq_match && !xfer_start),
    .blk_no_i (blk_no),
    .match_o  (seq_match),
    .dup_o    (seq_dup)
  );

  assign blk_en = rx_valid && ((state_q == ST_BLK0) || (state_q == ST_BLK1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      byte0_q    <= '0;
      data_wr_q  <= 1'b0;
      data_out_q <= '0;
      data_cnt_q <= '0;
      commit_q   <= 1'b0;
      discard_q  <= 1'b0;
      dup_q      <= 1'b0;
      err_q      <= 1'b0;
      ack_req_q  <= 1'b0;
      ack_blk_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      data_wr_q <= 1'b0;
      commit_q  <= 1'b0;
      discard_q <= 1'b0;
      dup_q     <= 1'b0;
      err_q     <= 1'b0;
      if (xfer_start) begin
        state_q   <= ST_IDLE;
        done_q    <= 1'b0;
        ack_req_q <= 1'b0;
        if (state_q inside {ST_OP1, ST_BLK0, ST_BLK1, ST_DATA, ST_CHECK})
          discard_q <= 1'b1;
      end else if (rx_valid && rx_sof &&
                   (state_q inside {ST_OP1, ST_BLK0, ST_BLK1, ST_DATA})) begin
        // A new packet cut in: abandon the current one and parse the new one
        discard_q  <= 1'b1;
        err_q      <= 1'b1;
        byte0_q    <= eth_data;
        data_cnt_q <= '0;
        state_q    <= rx_eof ? ST_IDLE : ST_OP1;
      end else begin
        case (state_q)
          ST_IDLE: if (rx_valid && rx_sof) begin
            if (rx_eof) begin
              err_q <= 1'b1;
            end else begin
              byte0_q    <= eth_data;
              data_cnt_q <= '0;
              state_q    <= ST_OP1;
            end
          end
          ST_OP1: if (rx_valid) begin
            if (rx_eof) begin
              err_q   <= 1'b1;
              state_q <= ST_IDLE;
            end else if ({byte0_q, eth_data} == OP_DATA) begin
              state_q <= ST_BLK0;
            end else begin
              err_q   <= 1'b1;
              state_q <= ST_DROP;
            end
          end
          ST_BLK0: if (rx_valid) begin
            if (rx_eof) err_q <= 1'b1;
            state_q <= rx_eof ? ST_IDLE : ST_BLK1;
          end
          ST_BLK1: if (rx_valid)
            state_q <= rx_eof ? ST_CHECK : ST_DATA;
          ST_DATA: if (rx_valid) begin
            if (data_cnt_q == CNT_MAX) begin
              // Oversized packet: the extra byte is never written
              discard_q <= 1'b1;
              err_q     <= 1'b1;
              state_q   <= rx_eof ? ST_IDLE : ST_DROP;
            end else begin
              data_wr_q  <= 1'b1;
              data_out_q <= eth_data;
              data_cnt_q <= data_cnt_q + 1'b1;
              if (rx_eof) state_q <= ST_CHECK;
            end
          end
          ST_CHECK: begin
            if (seq_match) begin
              commit_q  <= 1'b1;
              ack_blk_q <= blk_no;
              ack_req_q <= 1'b1;
              if (data_cnt_q < CNT_MAX) done_q <= 1'b1;
              state_q   <= ST_ACK_WAIT;
            end else if (seq_dup) begin
              discard_q <= 1'b1;
              dup_q     <= 1'b1;
              ack_blk_q <= blk_no;
              ack_req_q <= 1'b1;
              state_q   <= ST_ACK_WAIT;
            end else begin
              discard_q <= 1'b1;
              err_q     <= 1'b1;
              state_q   <= ST_IDLE;
            end
          end
          ST_ACK_WAIT: if (ack_done) begin
            ack_req_q <= 1'b0;
            state_q   <= ST_IDLE;
          end
          ST_DROP: if (rx_valid && rx_eof)
            state_q <= ST_IDLE;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign data_wr      = data_wr_q;
  assign data_out     = data_out_q;
  assign data_cnt     = data_cnt_q;
  assign data_commit  = commit_q;
  assign data_discard = discard_q;
  assign pkt_dup      = dup_q;
  assign pkt_err      = err_q;
  assign ack_req      = ack_req_q;
  assign ack_blk      = ack_blk_q;
  assign xfer_done    = done_q;

endmodule

// File: doc/tftp_rx_ctrl.md
Name: tftp_rx_ctrl

Overview:
Sequences the TFTP receive path for one incoming DATA packet at a time. It walks the UDP payload byte stream and drives the enable of the block-number decoder (blockno_decode) for the two block-number bytes. It then streams the data bytes out, compares the decoded block number against the expected one, and commits, re-acknowledges or discards the packet. It sits between the UDP payload extractor and the file buffer / ACK transmitter.

Parameters:
MAX_DATA, 512, maximum TFTP data bytes per packet; a packet with exactly MAX_DATA bytes is not the last one.
CNT_W, 10, width of the data byte counter; must hold MAX_DATA.
OP_DATA, 16'h0003, TFTP DATA opcode.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
xfer_start  in  1  pulse: new transfer, expected block := 1, clears xfer_done
rx_valid  in  1  eth_data holds a payload byte this cycle
rx_sof  in  1  qualifies first payload byte (with rx_valid)
rx_eof  in  1  qualifies last payload byte (with rx_valid)
eth_data  in  8  payload byte, MSB-first fields
blk_no  in  16  block number from blockno_decode, registered output
ack_done  in  1  ACK transmitter finished sending
blk_en  out  1  enable to blockno_decode
data_wr  out  1  data byte strobe to file buffer
data_out  out  8  data byte
data_cnt  out  CNT_W  bytes written in current packet
data_commit  out  1  pulse: keep speculatively written bytes
data_discard  out  1  pulse: drop speculatively written bytes
ack_req  out  1  request ACK of ack_blk, held until ack_done
ack_blk  out  16  block number to acknowledge
pkt_dup  out  1  pulse: duplicate packet received
pkt_err  out  1  pulse: malformed or out-of-sequence packet
xfer_done  out  1  level: last (short) block committed

Behaviour:
- Reset (async) values:
  - all outputs 0
  - state IDLE
  - expected block = 16'h0001
- States: IDLE, OP1, BLK0, BLK1, DATA, CHECK, ACK_WAIT, DROP.
- IDLE: on rx_valid&rx_sof, capture opcode byte 0 and go to OP1. Bytes without sof are ignored.
- OP1: on rx_valid, form opcode {byte0, eth_data}.
  - Opcode == OP_DATA: go to BLK0.
  - Otherwise: go to DROP and pulse pkt_err.
- BLK0, BLK1: blk_en = rx_valid (combinational). Each accepted byte advances the state; BLK1 goes to DATA.
- DATA: each rx_valid byte gives data_wr=1 and data_out=eth_data in the same cycle, registered, so 1-cycle latency; data_cnt increments.
  - A byte arriving when data_cnt==MAX_DATA is not written: pulse data_discard and pkt_err, go to DROP.
- EOF handling:
  - rx_eof on the BLK1 byte (zero-length data) goes to CHECK; this is legal and is the last block.
  - rx_eof in OP1 or BLK0: pulse pkt_err, go to IDLE.
  - rx_eof in DATA (that byte is written) goes to CHECK.
- CHECK (one cycle; blk_no is valid here):
  - blk_no == expected:
    - pulse data_commit
    - ack_blk := blk_no
    - expected := expected+1, wrapping 16'hFFFF to 16'h0000
    - if data_cnt < MAX_DATA, set xfer_done
    - go to ACK_WAIT
  - blk_no == expected-1 (mod 2^16): pulse data_discard and pkt_dup; ack_blk := blk_no; go to ACK_WAIT.
  - Otherwise: pulse data_discard and pkt_err; go to IDLE.
- ACK_WAIT:
  - ack_req=1 until the cycle ack_done is sampled high; then ack_req=0 next cycle and go to IDLE.
  - Incoming bytes are ignored, and a packet arriving here is lost.
- DROP: ignore bytes until rx_valid&rx_eof, then go to IDLE.
- rx_sof in OP1/BLK0/BLK1/DATA (restart):
  - pulse data_discard, plus pkt_err
  - the sof byte becomes opcode byte 0, go to OP1
  - data_cnt is cleared
- rx_sof&rx_eof together (1-byte packet): pkt_err, stay in IDLE.
- xfer_start:
  - honoured in any state
  - forces IDLE, expected := 1, xfer_done := 0, ack_req := 0
  - pulses data_discard if the controller was in OP1..CHECK.
- data_cnt clears on entry to OP1.

Decomposition:
- Shared tftp package: opcode constants (RRQ/WRQ/DATA/ACK/ERROR), MAX_DATA, state encoding.
- One natural sub-module, tftp_rx_seq_check: the combinational expected/duplicate comparator plus the expected-block register with wrap. Everything else stays in one FSM.

Test Plan:
1. Reset, xfer_start, packet 00 03 00 01 + 512 bytes, eof on last -> blk_en high 2 cycles, 512 data_wr, data_commit, ack_req with ack_blk=1, xfer_done=0; ack_done drops ack_req.
2. Then packet 00 03 00 02 + 3 bytes, eof -> data_commit, ack_blk=2, xfer_done=1, data_cnt=3.
3. Resend block 2 after its commit -> pkt_dup, data_discard, ack_blk=2, expected unchanged (block 3 next accepted).
4. Opcode 00 05 -> pkt_err, no blk_en, no data_wr, bytes until eof ignored; block 5 when expected 3 -> pkt_err, data_discard, no ack_req.
5. Expected forced to 16'hFFFF via sequence; accept block FFFF -> next accepted block 0000; 513-byte packet -> pkt_err at byte 513, data_discard.
6. Reset asserted mid-DATA -> outputs 0 immediately, expected=1; sof mid-packet -> data_discard+pkt_err, new packet decoded normally.
